// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage dcpu core: stall vector, exception flush
// and redirect PC, a one-cycle post-flush lockout, a stall watchdog and a stall counter.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter logic [15:0] WDOG_LIMIT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [31:0] ERET_CODE = 32'h0000000e;

  state_t      state_r;
  logic [15:0] wd_r;
  logic [16:0] wd_next_s;

  // Combinational stall/flush/redirect decode from requests, exception and FSM state
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h00000000;
    if (rst) begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = 32'h00000000;
    end else if ((state_r == RUN) && (excepttype_i != 32'h00000000)) begin
      flush = 1'b1;
      if (excepttype_i == ERET_CODE) begin
        new_pc = cp0_epc_i;
      end else begin
        new_pc = EXC_VECTOR;
      end
    end else if (stallreq_from_mem) begin
      stall = 6'b011111;
    end else if (stallreq_from_ex) begin
      stall = 6'b001111;
    end else if (stallreq_from_id) begin
      stall = 6'b000111;
    end else begin
      stall = 6'b000000;
    end
  end

  // Widened so the limit compare cannot alias when wd is at its saturation value
  assign wd_next_s = {1'b0, wd_r} + 17'd1;

  // FSM, watchdog, sticky timeout flag and stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      wd_r          <= 16'd0;
      stall_cnt     <= 32'd0;
      stall_timeout <= 1'b0;
    end else begin
      case (state_r)
        RUN:     state_r <= flush ? LOCK : RUN;
        LOCK:    state_r <= RUN;
        default: state_r <= RUN;
      endcase

      if (stall[0]) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end

      if (flush || !stall[0]) begin
        wd_r <= 16'd0;
      end else if (wd_r != 16'hFFFF) begin
        wd_r <= wd_next_s[15:0];
      end else begin
        wd_r <= wd_r;
      end

      if (stall[0] && !flush && (wd_next_s == {1'b0, WDOG_LIMIT})) begin
        stall_timeout <= 1'b1;
      end else begin
        stall_timeout <= stall_timeout;
      end
    end
  end

endmodule
